// File: rtl/snake_map_ctrl_if.sv
// Display-side bus of snake_map_ctrl: frame timing and player requests in, the map bitmap and status out.
interface snake_map_ctrl_if;
  logic         I_vs;
  logic         I_disp_busy;
  logic         I_dir_valid;
  logic [1:0]   I_dir;
  logic         I_restart;
  logic [255:0] O_map;
  logic         O_busy;
  logic         O_game_over;

  modport master (
    output I_vs, I_disp_busy, I_dir_valid, I_dir, I_restart,
    input  O_map, O_busy, O_game_over
  );

  modport slave (
    input  I_vs, I_disp_busy, I_dir_valid, I_dir, I_restart,
    output O_map, O_busy, O_game_over
  );
endinterface

// File: rtl/snake_map_ctrl.sv
// Fixed-length snake on a 16x16 bitmap, stepped every STEP_FRAMES frames while the display is blanked.
// Define SNAKE_WRAP_EN to make moves off an edge wrap around instead of ending the game.
module snake_map_ctrl #(
  parameter int STEP_FRAMES = 8,
  parameter int SNAKE_LEN   = 4
) (
  input  logic            I_pxl_clk,
  input  logic            I_rst_n,
  snake_map_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CLEAR, INIT, IDLE, WAIT_BLANK, CALC, CLR_TAIL, SET_HEAD, OVER
  } state_t;

  localparam logic [1:0] DIR_UP     = 2'd0;
  localparam logic [1:0] DIR_RIGHT  = 2'd1;
  localparam logic [1:0] DIR_DOWN   = 2'd2;
  localparam logic [3:0] INIT_ROW   = 4'd8;
  localparam logic [3:0] LAST_BODY  = 4'(SNAKE_LEN - 1);
  localparam logic [7:0] LAST_FRAME = 8'(STEP_FRAMES - 1);
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t       state_q, state_d;
  logic [255:0] map_q;
  logic [7:0]   pos_q [16];
  logic [3:0]   head_ptr_q;
  logic [3:0]   cnt_q;
  logic [7:0]   frame_q;
  logic [1:0]   dir_q, pend_q;
  logic         vs_q;
  logic [7:0]   new_head_q;

  logic [3:0]   tail_ptr;
  logic [7:0]   head_pos, tail_pos, next_pos;
  logic         off_edge, hit, vs_rise, dir_ok, busy_st;

  // Position {row, col} to bitmap bit: row-major, column 0 in the row's MSB.
  function automatic logic [7:0] cell_idx(input logic [7:0] pos);
    return {pos[7:4], ~pos[3:0]};
  endfunction

  assign tail_ptr = head_ptr_q - LAST_BODY;
  assign head_pos = pos_q[head_ptr_q];
  assign tail_pos = pos_q[tail_ptr];
  assign vs_rise  = bus.I_vs & ~vs_q;
  assign dir_ok   = bus.I_dir_valid && (bus.I_dir != (dir_q ^ 2'b10));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    next_pos = head_pos;
    off_edge = 1'b0;
    case (pend_q)
      DIR_UP: begin
        next_pos[7:4] = head_pos[7:4] - 4'd1;
        off_edge      = (head_pos[7:4] == 4'd0);
      end
      DIR_RIGHT: begin
        next_pos[3:0] = head_pos[3:0] + 4'd1;
        off_edge      = (head_pos[3:0] == 4'd15);
      end
      DIR_DOWN: begin
        next_pos[7:4] = head_pos[7:4] + 4'd1;
        off_edge      = (head_pos[7:4] == 4'd15);
      end
      default: begin
        next_pos[3:0] = head_pos[3:0] - 4'd1;
        off_edge      = (head_pos[3:0] == 4'd0);
      end
    endcase
  end

  // The vacating tail cell is still set in the map but is a legal target.
  assign hit = (off_edge && !WRAP) || (map_q[cell_idx(next_pos)] && (next_pos != tail_pos));

  always_comb begin
    state_d = state_q;
    busy_st = 1'b0;
    case (state_q)
      CLEAR:      begin busy_st = 1'b1; if (cnt_q == 4'd15) state_d = INIT; end
      INIT:       begin busy_st = 1'b1; if (cnt_q == LAST_BODY) state_d = IDLE; end
      IDLE:       if (vs_rise && (frame_q == LAST_FRAME)) state_d = WAIT_BLANK;
      WAIT_BLANK: if (!bus.I_disp_busy) state_d = CALC;
      CALC:       begin busy_st = 1'b1; state_d = hit ? OVER : CLR_TAIL; end
      CLR_TAIL:   begin busy_st = 1'b1; state_d = SET_HEAD; end
      SET_HEAD:   begin busy_st = 1'b1; state_d = IDLE; end
      OVER:       if (bus.I_restart) state_d = CLEAR;
      default:    state_d = CLEAR;
    endcase
  end

  assign bus.O_map       = map_q;
  assign bus.O_busy      = I_rst_n & busy_st;
  assign bus.O_game_over = (state_q == OVER);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!I_rst_n) begin
      state_q    <= CLEAR;
      map_q      <= '0;
      head_ptr_q <= '0;
      cnt_q      <= '0;
      frame_q    <= '0;
      dir_q      <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      vs_q       <= 1'b0;
      new_head_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= bus.I_vs;
      if (((state_q == IDLE) || (state_q == WAIT_BLANK)) && dir_ok) pend_q <= bus.I_dir;
      case (state_q)
        CLEAR: begin
          map_q[{cnt_q, 4'h0} +: 16] <= '0;
          cnt_q                      <= cnt_q + 4'd1;
        end
        INIT: begin
          map_q[{INIT_ROW, ~cnt_q}] <= 1'b1;
          head_ptr_q                <= cnt_q;
          cnt_q                     <= (cnt_q == LAST_BODY) ? 4'd0 : cnt_q + 4'd1;
          frame_q                   <= '0;
          dir_q                     <= DIR_RIGHT;
          pend_q                    <= DIR_RIGHT;
        end
        IDLE: if (vs_rise) frame_q <= (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
        CALC:     new_head_q <= next_pos;
        CLR_TAIL: map_q[cell_idx(tail_pos)] <= 1'b0;
        SET_HEAD: begin
          map_q[cell_idx(new_head_q)] <= 1'b1;
          head_ptr_q                  <= head_ptr_q + 4'd1;
          dir_q                       <= pend_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the position buffer has no reset; INIT rewrites every live entry before it is read.
  always_ff @(posedge I_pxl_clk) begin
    if (state_q == INIT) pos_q[cnt_q] <= {INIT_ROW, cnt_q};
    else if (state_q == SET_HEAD) pos_q[head_ptr_q + 4'd1] <= new_head_q;
  end

endmodule

// File: tb/tb_snake_map_ctrl.sv
// Self-checking bench for snake_map_ctrl: step table plus restart, reset and blanking sequences,
// with expected maps from a snake model queued when a step is driven and compared when it lands.
module tb_snake_map_ctrl;

  localparam int STEP_FRAMES = 8;
  localparam int SNAKE_LEN   = 4;

  typedef struct {
    bit         dv;
    logic [1:0] dir;
    bit         restart;
    bit         hold;
    int         row;
    int         col;
    bit         over;
  } step_vec_t;

  typedef struct {
    logic [255:0] map;
    bit           over;
  } exp_t;

  logic clk;
  logic rst_n;
  snake_map_ctrl_if bus ();

  snake_map_ctrl #(.STEP_FRAMES(STEP_FRAMES), .SNAKE_LEN(SNAKE_LEN)) dut (
    .I_pxl_clk(clk),
    .I_rst_n  (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           busy_cnt = 0;
  exp_t         sb_q[$];
  logic [255:0] m_map;
  logic [7:0]   m_body[$];
  logic [1:0]   m_dir, m_pend;
  bit           m_over;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int bidx(input logic [7:0] p);
    return 16 * int'(p[7:4]) + 15 - int'(p[3:0]);
  endfunction

  function automatic step_vec_t mk(input bit dv, input logic [1:0] dir, input bit rq, input bit hold,
                                   input int row, input int col, input bit over);
    step_vec_t v;
    v.dv = dv; v.dir = dir; v.restart = rq; v.hold = hold;
    v.row = row; v.col = col; v.over = over;
    return v;
  endfunction

  task automatic model_init();
    m_map = '0;
    m_body.delete();
    for (int c = 0; c < SNAKE_LEN; c++) begin
      m_body.push_back({4'd8, 4'(c)});
      m_map[bidx({4'd8, 4'(c)})] = 1'b1;
    end
    m_dir = 2'd1; m_pend = 2'd1; m_over = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] h;
    logic [3:0] r, c;
    bit off;
    h = m_body[m_body.size() - 1];
    r = h[7:4]; c = h[3:0]; off = 1'b0;
    case (m_pend)
      2'd0: begin off = (r == 4'd0);  r = r - 4'd1; end
      2'd1: begin off = (c == 4'd15); c = c + 4'd1; end
      2'd2: begin off = (r == 4'd15); r = r + 4'd1; end
      default: begin off = (c == 4'd0); c = c - 4'd1; end
    endcase
`ifdef SNAKE_WRAP_EN
    off = 1'b0;
`endif
    if (off || (m_map[bidx({r, c})] && ({r, c} != m_body[0]))) m_over = 1'b1;
    else begin
      m_map[bidx(m_body[0])] = 1'b0;
      void'(m_body.pop_front());
      m_map[bidx({r, c})] = 1'b1;
      m_body.push_back({r, c});
      m_dir = m_pend;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (bus.O_busy) busy_cnt++;
  endtask

  task automatic vs_pulse();
    bus.I_vs = 1'b1; cycle(); cycle();
    bus.I_vs = 1'b0; cycle(); cycle();
  endtask

  // Expects the controller to have just left IDLE/OVER for CLEAR on the previous edge (or reset release).
  task automatic wait_init(input string tag);
    repeat (19) cycle();
    check($sformatf("%s_busy_in_init", tag), bus.O_busy, 1'b1);
    cycle();
    check($sformatf("%s_busy_idle", tag), bus.O_busy, 1'b0);
    check($sformatf("%s_over", tag), bus.O_game_over, 1'b0);
    check($sformatf("%s_row8", tag), bus.O_map[143:128], 16'hF000);
    check($sformatf("%s_map", tag), bus.O_map, m_map);
  endtask

  task automatic run_step(input step_vec_t v, input string tag);
    exp_t e;
    int k, changed;
    bit done;
    logic [255:0] snap;
    bus.I_dir_valid = v.dv; bus.I_dir = v.dir; bus.I_restart = v.restart;
    cycle();
    bus.I_dir_valid = 1'b0; bus.I_restart = 1'b0;
    if (v.dv && (v.dir != (m_dir ^ 2'b10))) m_pend = v.dir;
    model_step();
    e.map = m_map; e.over = m_over;
    sb_q.push_back(e);
    busy_cnt = 0;
    repeat (STEP_FRAMES - 1) vs_pulse();
    check($sformatf("%s_early_busy", tag), busy_cnt, 0);
    bus.I_disp_busy = v.hold;
    vs_pulse();
    if (v.hold) begin
      snap = bus.O_map; changed = 0;
      for (int i = 0; i < 500; i++) begin
        bus.I_vs = ((i % 50) < 2);
        cycle();
        if (bus.O_map !== snap) changed++;
      end
      bus.I_vs = 1'b0;
      check($sformatf("%s_hold_changes", tag), changed, 0);
      check($sformatf("%s_hold_busy", tag), busy_cnt, 0);
      bus.I_disp_busy = 1'b0;
    end
    done = 1'b0;
    for (k = 1; k <= 40; k++) begin
      cycle();
      if ((busy_cnt > 0) && !bus.O_busy) begin done = 1'b1; break; end
    end
    check($sformatf("%s_finished", tag), done, 1'b1);
    if (v.hold) check($sformatf("%s_commit_le4", tag), (k <= 4), 1'b1);
    e = sb_q.pop_front();
    check($sformatf("%s_map", tag), bus.O_map, e.map);
    check($sformatf("%s_over", tag), bus.O_game_over, e.over);
    if (!v.over) begin
      check($sformatf("%s_busy_cycles", tag), busy_cnt, 3);
      check($sformatf("%s_head", tag), bus.O_map[16 * v.row + 15 - v.col], 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    step_vec_t vecs[6];
    step_vec_t last;
    bit seen;
    vecs[0] = mk(1'b1, 2'd3, 1'b0, 1'b0, 8, 4, 1'b0);  // reversal ignored
    vecs[1] = mk(1'b1, 2'd2, 1'b0, 1'b1, 9, 4, 1'b0);  // down, step held by display
    vecs[2] = mk(1'b1, 2'd3, 1'b1, 1'b0, 9, 3, 1'b0);  // left, restart ignored
    vecs[3] = mk(1'b1, 2'd0, 1'b0, 1'b0, 8, 3, 1'b0);  // up onto vacating tail
    vecs[4] = mk(1'b0, 2'd0, 1'b0, 1'b0, 7, 3, 1'b0);
    vecs[5] = mk(1'b1, 2'd1, 1'b0, 1'b0, 7, 4, 1'b0);

    rst_n = 1'b0;
    bus.I_vs = 1'b0; bus.I_disp_busy = 1'b0; bus.I_dir_valid = 1'b0;
    bus.I_dir = 2'd0; bus.I_restart = 1'b0;
    model_init();
    repeat (3) @(negedge clk);
    check("rst_map", bus.O_map, 256'd0);
    check("rst_busy", bus.O_busy, 1'b0);
    check("rst_over", bus.O_game_over, 1'b0);
    rst_n = 1'b1;
    wait_init("por");

    for (int i = 0; i < 6; i++) begin
      run_step(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) check("vec0_row8", bus.O_map[143:128], 16'h7800);
    end
    check("tail_cell_kept", bus.O_map[bidx({4'd8, 4'd3})], 1'b1);

    for (int i = 0; i < 11; i++)
      run_step(mk(1'b0, 2'd0, 1'b0, 1'b0, 7, 5 + i, 1'b0), $sformatf("right%0d", i));

`ifdef SNAKE_WRAP_EN
    last = mk(1'b0, 2'd0, 1'b0, 1'b0, 7, 0, 1'b0);
    run_step(last, "edge_wrap");
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    model_init();
    wait_init("reinit");
`else
    last = mk(1'b0, 2'd0, 1'b0, 1'b0, 7, 15, 1'b1);
    run_step(last, "edge_over");
    bus.I_dir_valid = 1'b1; bus.I_dir = 2'd2;
    cycle();
    bus.I_dir_valid = 1'b0;
    repeat (STEP_FRAMES + 2) vs_pulse();
    check("over_frozen_map", bus.O_map, m_map);
    check("over_still", bus.O_game_over, 1'b1);
    check("over_busy", bus.O_busy, 1'b0);
    bus.I_restart = 1'b1;
    cycle();
    bus.I_restart = 1'b0;
    check("restart_busy", bus.O_busy, 1'b1);
    model_init();
    wait_init("restart");
`endif

    run_step(mk(1'b1, 2'd3, 1'b0, 1'b0, 8, 4, 1'b0), "rev_again");
    run_step(mk(1'b1, 2'd0, 1'b0, 1'b0, 7, 4, 1'b0), "turn_up");

    repeat (STEP_FRAMES - 1) vs_pulse();
    bus.I_vs = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (bus.O_busy) begin seen = 1'b1; break; end
    end
    check("midstep_busy_seen", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midstep_rst_map", bus.O_map, 256'd0);
    check("midstep_rst_busy", bus.O_busy, 1'b0);
    check("midstep_rst_over", bus.O_game_over, 1'b0);
    bus.I_vs = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    model_init();
    wait_init("rst2");
    run_step(mk(1'b0, 2'd0, 1'b0, 1'b0, 8, 4, 1'b0), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
